// File: rtl/booth_seq_ctrl.sv
// Sequential radix-2 Booth multiplier: one step datapath plus the
// IDLE/ITER/DONE controller with valid/ready on operands and product.
module booth_multi #(
    parameter int N = 8
) (
    input  logic [N-1:0] i_a,
    input  logic [N-1:0] i_m,
    input  logic [N:0]   i_q,
    output logic [N-1:0] o_a,
    output logic [N:0]   o_q
);
    logic [N:0] w_ae;
    logic [N:0] w_me;
    logic [N:0] w_sum;

    assign w_ae = {i_a[N-1], i_a};
    assign w_me = {i_m[N-1], i_m};

    // The low N bits are the mod-2**N A+/-M; the extra top bit is the true
    // sign, so the arithmetic shift stays exact for -2**(N-1) operands.
    always_comb begin
        w_sum = w_ae;
        unique case (i_q[1:0])
            2'b01:   w_sum = w_ae + w_me;
            2'b10:   w_sum = w_ae - w_me;
            default: w_sum = w_ae;
        endcase
    end

    assign o_a = w_sum[N:1];
    assign o_q = {w_sum[0], i_q[N:1]};
endmodule

module booth_seq_ctrl #(
    parameter int N     = 8,
    parameter int CNT_W = 4
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           in_valid,
    output logic           in_ready,
    input  logic [N-1:0]   mcand,
    input  logic [N-1:0]   mplier,
    input  logic           abort,
    output logic           out_valid,
    input  logic           out_ready,
    output logic [2*N-1:0] product,
    output logic           busy
);
    typedef enum logic [1:0] {
        S_IDLE,
        S_ITER,
        S_DONE
    } state_t;

    state_t           r_state;
    state_t           w_next;
    logic [N-1:0]     r_a;
    logic [N:0]       r_q;
    logic [N-1:0]     r_m;
    logic [CNT_W-1:0] r_cnt;
    logic [2*N-1:0]   r_product;

    logic             w_load;
    logic             w_step;
    logic             w_clear;
    logic             w_latch;
    logic [N-1:0]     w_a_out;
    logic [N:0]       w_q_out;

    booth_multi #(.N(N)) u_step (
        .i_a (r_a),
        .i_m (r_m),
        .i_q (r_q),
        .o_a (w_a_out),
        .o_q (w_q_out)
    );

    always_comb begin
        w_next  = r_state;
        w_load  = 1'b0;
        w_step  = 1'b0;
        w_clear = 1'b0;
        w_latch = 1'b0;
        unique case (r_state)
            S_IDLE: begin
                if (in_valid) begin
                    w_next = S_ITER;
                    w_load = 1'b1;
                end
            end
            S_ITER: begin
                if (abort) begin
                    w_next  = S_IDLE;
                    w_clear = 1'b1;
                end else begin
                    w_step = 1'b1;
                    if (r_cnt == CNT_W'(1)) begin
                        w_next  = S_DONE;
                        w_latch = 1'b1;
                    end
                end
            end
            S_DONE: begin
                // abort beats a same-cycle transfer
                if (abort) begin
                    w_next  = S_IDLE;
                    w_clear = 1'b1;
                end else if (out_ready) begin
                    w_next = S_IDLE;
                end
            end
            default: w_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state   <= S_IDLE;
            r_a       <= '0;
            r_q       <= '0;
            r_m       <= '0;
            r_cnt     <= '0;
            r_product <= '0;
        end else begin
            r_state <= w_next;
            if (w_load) begin
                r_a   <= '0;
                r_q   <= {mplier, 1'b0};
                r_m   <= mcand;
                r_cnt <= CNT_W'(N);
            end
            if (w_step) begin
                r_a   <= w_a_out;
                r_q   <= w_q_out;
                r_cnt <= r_cnt - 1'b1;
            end
            if (w_latch) begin
                r_product <= {w_a_out, w_q_out[N:1]};
            end
            if (w_clear) begin
                r_a   <= '0;
                r_q   <= '0;
                r_cnt <= '0;
            end
        end
    end

    assign in_ready  = (r_state == S_IDLE);
    assign out_valid = (r_state == S_DONE);
    assign busy      = (r_state != S_IDLE);
    assign product   = r_product;
endmodule

// File: tb/tb_booth_seq_ctrl.sv
// Scoreboard bench for booth_seq_ctrl: stimulus pushes expected products,
// a negedge monitor pops and compares on every accepted transfer.
module tb_booth_seq_ctrl;
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [7:0]  mcand = '0;
    logic [7:0]  mplier = '0;
    logic        abort = 1'b0;
    logic        out_valid;
    logic        out_ready = 1'b1;
    logic [15:0] product;
    logic        busy;

    int errors = 0;
    int checks = 0;
    logic [15:0] exp_q[$];

    always #5 clk = ~clk;

    booth_seq_ctrl #(.N(8), .CNT_W(4)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .mcand     (mcand),
        .mplier    (mplier),
        .abort     (abort),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .product   (product),
        .busy      (busy)
    );

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, req);
        end
    endtask

    // Monitor: one compare per completed transfer
    always @(negedge clk) begin
        if (!rst && out_valid && out_ready && !abort) begin
            checks++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL unexpected_output: got %0h expected none",
                         product);
            end else begin
                logic [15:0] e;
                e = exp_q.pop_front();
                if (product !== e) begin
                    errors++;
                    $display("FAIL product: got %0h expected %0h",
                             product, e);
                end
            end
        end
    end

    task automatic send(input logic [7:0] a, input logic [7:0] b,
                        input logic [15:0] e, input bit push);
        int n;
        n = 0;
        @(negedge clk);
        while (!in_ready && n < 200) begin
            @(negedge clk);
            n++;
        end
        if (!in_ready) chk("send_timeout", 32'(in_ready), 32'd1);
        in_valid = 1'b1;
        mcand    = a;
        mplier   = b;
        if (push) exp_q.push_back(e);
        @(posedge clk);
        #1 in_valid = 1'b0;
    endtask

    task automatic drain();
        int n;
        n = 0;
        while (exp_q.size() != 0 && n < 500) begin
            @(negedge clk);
            n++;
        end
        chk("drain", exp_q.size(), 0);
        @(negedge clk);
    endtask

    task automatic wait_valid();
        int n;
        n = 0;
        @(negedge clk);
        while (!out_valid && n < 100) begin
            @(negedge clk);
            n++;
        end
        chk("wait_valid", 32'(out_valid), 32'd1);
    endtask

    task automatic model_op(input logic [7:0] a, input logic [7:0] b);
        int ia;
        int ib;
        ia = int'($signed(a));
        ib = int'($signed(b));
        send(a, b, 16'(ia * ib), 1'b1);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int k;
        logic [15:0] p;
        bit stable;
        // reset state
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        chk("rst_in_ready", 32'(in_ready), 32'd1);
        chk("rst_out_valid", 32'(out_valid), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_product", 32'(product), 32'd0);

        // 1: latency N+1, in_ready low throughout
        send(8'd3, 8'd5, 16'h000F, 1'b1);
        k = 0;
        stable = 1'b1;
        do begin
            @(negedge clk);
            k++;
            if (!out_valid && (in_ready || !busy)) stable = 1'b0;
        end while (!out_valid && k < 50);
        chk("latency", k, 9);
        chk("in_ready_low", 32'(stable), 32'd1);
        drain();

        // 2: most-negative and sign corners
        send(8'h80, 8'h80, 16'h4000, 1'b1);
        send(8'd127, 8'h80, 16'hC080, 1'b1);
        send(8'hFF, 8'd1, 16'hFFFF, 1'b1);
        send(8'hF9, 8'd6, 16'hFFD6, 1'b1);
        drain();

        // 3: backpressure
        @(posedge clk);
        #1 out_ready = 1'b0;
        send(8'd12, 8'hF6, 16'hFF88, 1'b1);
        wait_valid();
        p = product;
        stable = 1'b1;
        repeat (20) begin
            @(negedge clk);
            if (!out_valid || product !== p || in_ready) stable = 1'b0;
        end
        chk("bp_stable", 32'(stable), 32'd1);
        chk("bp_product", 32'(p), 32'hFF88);
        @(posedge clk);
        #1 out_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        chk("bp_in_ready", 32'(in_ready), 32'd1);
        chk("bp_single", 32'(out_valid), 32'd0);
        chk("bp_popped", exp_q.size(), 0);

        // 4: in_valid held during ITER is ignored
        send(8'd3, 8'd5, 16'h000F, 1'b1);
        in_valid = 1'b1;
        mcand    = 8'd7;
        mplier   = 8'd9;
        exp_q.push_back(16'd63);
        k = 0;
        @(negedge clk);
        while (!in_ready && k < 100) begin
            @(negedge clk);
            k++;
        end
        chk("hold_wait", k, 9);
        @(posedge clk);
        #1 in_valid = 1'b0;
        drain();

        // 5: reset mid-iteration
        send(8'd3, 8'd5, 16'h0, 1'b0);
        repeat (3) @(posedge clk);
        #1 rst = 1'b1;
        @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        chk("mid_rst_in_ready", 32'(in_ready), 32'd1);
        chk("mid_rst_busy", 32'(busy), 32'd0);
        chk("mid_rst_valid", 32'(out_valid), 32'd0);
        chk("mid_rst_product", 32'(product), 32'd0);
        send(8'd3, 8'd5, 16'h000F, 1'b1);
        drain();

        // 6a: abort in ITER
        send(8'd9, 8'd9, 16'h0, 1'b0);
        @(posedge clk);
        #1 abort = 1'b1;
        @(posedge clk);
        #1 abort = 1'b0;
        @(negedge clk);
        chk("abort_iter_ready", 32'(in_ready), 32'd1);
        chk("abort_iter_valid", 32'(out_valid), 32'd0);

        // 6b: abort in DONE together with out_ready
        @(posedge clk);
        #1 out_ready = 1'b0;
        send(8'd10, 8'd10, 16'h0, 1'b0);
        wait_valid();
        @(posedge clk);
        #1 begin
            abort     = 1'b1;
            out_ready = 1'b1;
        end
        @(posedge clk);
        #1 abort = 1'b0;
        @(negedge clk);
        chk("abort_done_ready", 32'(in_ready), 32'd1);
        chk("abort_done_valid", 32'(out_valid), 32'd0);

        // random signed operands against the model
        for (int i = 0; i < 12; i++) begin
            model_op(8'($urandom_range(255)), 8'($urandom_range(255)));
        end
        drain();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
